// File: rtl/fifo_pkg.sv
// Shared pointer encoding for the dual-clock FIFO controllers: Gray conversion and
// offset pointer space that lets any depth (not only powers of two) keep single-bit steps.
package fifo_pkg;

   localparam int PTR_MAX_W = 32;

   typedef logic [PTR_MAX_W-1:0] ptr_word_t;

   typedef struct packed {
      logic full;
      logic almost_full;
   } wflags_t;

   function automatic ptr_word_t bin2gray(input ptr_word_t bin);
      return bin ^ (bin >> 1);
   endfunction

   // Prefix XOR from the MSB down; callers zero-extend so unused high bits stay 0.
   function automatic ptr_word_t gray2bin(input ptr_word_t gray);
      ptr_word_t bin;
      bin = gray;
      for (int i = 1; i < PTR_MAX_W; i++) begin
         bin = bin ^ (gray >> i);
      end
      return bin;
   endfunction

   // Pointers run over the centre 2*depth codes of a 2^(clog2(depth)+1) space, so the
   // mirror symmetry of the reflected Gray code keeps the wrap a single-bit change.
   function automatic int ptr_offset(input int depth);
      int pw;
      pw = $clog2(depth) + 1;
      return ((1 << pw) / 2) - depth;
   endfunction

   function automatic ptr_word_t ptr_normalise(input ptr_word_t bin, input int offset);
      return bin - ptr_word_t'(offset);
   endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains; presents
// the synchronised value converted back to binary. Shared by both FIFO sides.
module fifo_ptr_sync
   import fifo_pkg::*;
#(
   parameter int              W       = 7,
   parameter int              STAGES  = 2,
   parameter logic [W-1:0]    RST_VAL = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  gray_in,
   output logic [W-1:0]  bin_out
);

   logic [W-1:0] sync_q [STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_q[i] <= RST_VAL;
         end
      end else begin
         sync_q[0] <= gray_in;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign bin_out = W'(gray2bin(ptr_word_t'(sync_q[STAGES-1])));

endmodule

// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer/full controller for the dual-clock FIFO, any DATADEPTH >= 2.
// Optional sticky overflow flag enabled by defining FIFO_WPTR_OVERFLOW_EN.
module fifo_wptr_ctrl
   import fifo_pkg::*;
#(
   parameter int  DATADEPTH    = 45,
   parameter int  AFULL_MARGIN = 4,
   parameter int  SYNC_STAGES  = 2,
   localparam int AW           = $clog2(DATADEPTH),
   localparam int PW           = AW + 1
) (
   input  logic           wclk,
   input  logic           w_rst,
   input  logic           wr_en,
   input  logic [PW-1:0]  rptr_gray,
   output logic [AW-1:0]  waddr,
   output logic           wr_ack,
   output logic [PW-1:0]  wptr_gray,
   output logic           full,
   output logic           almost_full,
   output logic [PW-1:0]  wcount,
   output logic           overflow
);

   localparam int            PWE    = PW + 1;
   localparam int            S      = ptr_offset(DATADEPTH);
   localparam int            N      = 1 << PW;
   localparam logic [PW-1:0] S_P    = PW'(S);
   localparam logic [PW-1:0] LAST_P = PW'(N - 1 - S);
   localparam logic [PW-1:0] D_P    = PW'(DATADEPTH);
   localparam logic [PW-1:0] AF_P   = PW'(DATADEPTH - AFULL_MARGIN);
   localparam logic [PWE-1:0] D2_E  = PWE'(2 * DATADEPTH);
   localparam logic [PW-1:0] S_GRAY = PW'(bin2gray(ptr_word_t'(S)));

   logic [PW-1:0]  wbin_q, wbin_next;
   logic [PW-1:0]  wgray_q;
   logic [PW-1:0]  p_cur, p_next;
   logic [PW-1:0]  rbin, rp;
   logic [PW-1:0]  wcount_q, wcount_next;
   logic [PWE-1:0] diff_raw;
   wflags_t        flags_q, flags_next;

   // Handshake: wr_en is the writer's request; wr_ack (same cycle, combinational) is the
   // grant and RAM strobe. A request seen while full is simply not acked and not retried.
   assign wr_ack = wr_en && !flags_q.full;

   assign p_cur = PW'(ptr_normalise(ptr_word_t'(wbin_q), S));

   always_comb begin
      waddr = AW'(p_cur);
      if (p_cur >= D_P) begin
         waddr = AW'(p_cur - D_P);
      end
   end

   always_comb begin
      wbin_next = wbin_q;
      if (wr_ack) begin
         wbin_next = (wbin_q == LAST_P) ? S_P : wbin_q + PW'(1);
      end
   end

   fifo_ptr_sync #(
      .W       (PW),
      .STAGES  (SYNC_STAGES),
      .RST_VAL (S_GRAY)
   ) u_rptr_sync (
      .clk     (wclk),
      .rst     (w_rst),
      .gray_in (rptr_gray),
      .bin_out (rbin)
   );

   assign p_next = PW'(ptr_normalise(ptr_word_t'(wbin_next), S));
   assign rp     = PW'(ptr_normalise(ptr_word_t'(rbin), S));

   // Biased by 2D so the subtraction never goes negative; one conditional wrap suffices.
   always_comb begin
      diff_raw    = {1'b0, p_next} + D2_E - {1'b0, rp};
      wcount_next = PW'(diff_raw);
      if (diff_raw >= D2_E) begin
         wcount_next = PW'(diff_raw - D2_E);
      end
      flags_next.full        = (wcount_next == D_P);
      flags_next.almost_full = (wcount_next >= AF_P);
   end

   always_ff @(posedge wclk) begin
      if (w_rst) begin
         wbin_q   <= S_P;
         wgray_q  <= S_GRAY;
         wcount_q <= '0;
         flags_q  <= '0;
      end else begin
         wbin_q   <= wbin_next;
         wgray_q  <= PW'(bin2gray(ptr_word_t'(wbin_next)));
         wcount_q <= wcount_next;
         flags_q  <= flags_next;
      end
   end

   assign wptr_gray   = wgray_q;
   assign wcount      = wcount_q;
   assign full        = flags_q.full;
   assign almost_full = flags_q.almost_full;

`ifdef FIFO_WPTR_OVERFLOW_EN
   logic overflow_q;

   always_ff @(posedge wclk) begin
      if (w_rst) begin
         overflow_q <= 1'b0;
      end else if (wr_en && flags_q.full) begin
         overflow_q <= 1'b1;
      end
   end

   assign overflow = overflow_q;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Scoreboard bench for fifo_wptr_ctrl: D=45 instance for the main scenarios and a
// D=16 instance for the power-of-two case; expectations are hand-derived per scenario.
module tb_fifo_wptr_ctrl;

   localparam int D  = 45;
   localparam int S  = 19;
   localparam int DB = 16;

`ifdef FIFO_WPTR_OVERFLOW_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   // clock / reset
   logic wclk = 1'b0;
   always #5 wclk = ~wclk;

   logic       w_rst;
   logic       wr_en;
   logic [6:0] rptr_a;
   logic [4:0] rptr_b;

   logic [5:0] waddr_a;
   logic       wr_ack_a, full_a, af_a, ovf_a;
   logic [6:0] wptr_a, wcount_a;

   logic [3:0] waddr_b;
   logic       wr_ack_b, full_b, af_b, ovf_b;
   logic [4:0] wptr_b, wcount_b;

   fifo_wptr_ctrl #(.DATADEPTH(D), .AFULL_MARGIN(4), .SYNC_STAGES(2)) u_dut_a (
      .wclk        (wclk),
      .w_rst       (w_rst),
      .wr_en       (wr_en),
      .rptr_gray   (rptr_a),
      .waddr       (waddr_a),
      .wr_ack      (wr_ack_a),
      .wptr_gray   (wptr_a),
      .full        (full_a),
      .almost_full (af_a),
      .wcount      (wcount_a),
      .overflow    (ovf_a)
   );

   fifo_wptr_ctrl #(.DATADEPTH(DB), .AFULL_MARGIN(4), .SYNC_STAGES(2)) u_dut_b (
      .wclk        (wclk),
      .w_rst       (w_rst),
      .wr_en       (wr_en),
      .rptr_gray   (rptr_b),
      .waddr       (waddr_b),
      .wr_ack      (wr_ack_b),
      .wptr_gray   (wptr_b),
      .full        (full_b),
      .almost_full (af_b),
      .wcount      (wcount_b),
      .overflow    (ovf_b)
   );

   typedef struct packed {
      logic       dut;
      logic       ack;
      logic [6:0] waddr;
      logic       full;
      logic       af;
      logic [6:0] cnt;
      logic [6:0] wg;
      logic       ovf;
   } obs_t;

   localparam int OBS_W = $bits(obs_t);

   logic [OBS_W-1:0] exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   obs_idx  = 0;
   logic obs_v    = 1'b0;

   function automatic int g(input int x);
      return x ^ (x >> 1);
   endfunction

   function automatic obs_t mk(input logic dut, input logic ack, input int waddr,
                               input logic full, input logic af, input int cnt,
                               input int wg, input logic ovf);
      obs_t e;
      e.dut   = dut;
      e.ack   = ack;
      e.waddr = 7'(waddr);
      e.full  = full;
      e.af    = af;
      e.cnt   = 7'(cnt);
      e.wg    = 7'(wg);
      e.ovf   = ovf;
      return e;
   endfunction

   // driver: one call per cycle, inputs change 1 time unit after the rising edge
   task automatic drive(input logic rst, input logic we, input int rp,
                        input logic do_obs, input obs_t e);
      @(posedge wclk);
      #1;
      w_rst  = rst;
      wr_en  = we;
      rptr_a = 7'(g(S + rp));
      rptr_b = 5'(g(rp));
      obs_v  = do_obs;
      if (do_obs) exp_q.push_back(e);
   endtask

   task automatic reset_all();
      repeat (3) drive(1'b1, 1'b0, 0, 1'b0, '0);
   endtask

   task automatic cmp(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s obs=%0d actual=%0d required=%0d", name, obs_idx, act, req);
      end
   endtask

   // monitor / scoreboard
   obs_t mon_e;
   int   a_ack, a_waddr, a_full, a_af, a_cnt, a_wg, a_ovf;

   always @(negedge wclk) begin
      if (obs_v) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow obs=%0d actual=0 required=1", obs_idx);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.dut) begin
               a_ack = int'(wr_ack_b);  a_waddr = int'(waddr_b); a_full = int'(full_b);
               a_af  = int'(af_b);      a_cnt   = int'(wcount_b); a_wg = int'(wptr_b);
               a_ovf = int'(ovf_b);
            end else begin
               a_ack = int'(wr_ack_a);  a_waddr = int'(waddr_a); a_full = int'(full_a);
               a_af  = int'(af_a);      a_cnt   = int'(wcount_a); a_wg = int'(wptr_a);
               a_ovf = int'(ovf_a);
            end
            cmp("wr_ack",      a_ack,   int'(mon_e.ack));
            cmp("waddr",       a_waddr, int'(mon_e.waddr));
            cmp("full",        a_full,  int'(mon_e.full));
            cmp("almost_full", a_af,    int'(mon_e.af));
            cmp("wcount",      a_cnt,   int'(mon_e.cnt));
            cmp("wptr_gray",   a_wg,    int'(mon_e.wg));
            cmp("overflow",    a_ovf,   int'(mon_e.ovf));
         end
         obs_idx++;
      end
   end

   initial begin
      #100us;
      $display("FAIL watchdog obs=%0d actual=timeout required=finish", obs_idx);
      $fatal(1, "watchdog expired");
   end

   initial begin
      w_rst  = 1'b1;
      wr_en  = 1'b0;
      rptr_a = 7'(g(S));
      rptr_b = 5'd0;
      reset_all();

      // reset state
      drive(1'b0, 1'b0, 0, 1'b1, mk(0, 0, 0, 0, 0, 0, g(S), 0));

      // fill to full: almost_full once 41 entries are held, full at 45
      for (int i = 0; i < D; i++)
         drive(1'b0, 1'b1, 0, 1'b1, mk(0, 1, i, 0, (i >= 41), i, g(S + i), 0));

      // write while full: refused, overflow visible one cycle later when enabled
      drive(1'b0, 1'b1, 0, 1'b1, mk(0, 0, 0, 1, 1, D, g(S + D), 0));
      drive(1'b0, 1'b1, 0, 1'b1, mk(0, 0, 0, 1, 1, D, g(S + D), OVF_EN));

      // read pointer jumps to 10: full holds for 3 observed cycles, then releases
      for (int k = 0; k < 3; k++)
         drive(1'b0, 1'b0, 10, 1'b1, mk(0, 0, 0, 1, 1, D, g(S + D), OVF_EN));
      drive(1'b0, 1'b0, 10, 1'b1, mk(0, 0, 0, 0, 0, 35, g(S + D), OVF_EN));
      drive(1'b0, 1'b1, 10, 1'b1, mk(0, 1, 0, 0, 0, 35, g(S + D), OVF_EN));
      drive(1'b0, 1'b0, 10, 1'b1, mk(0, 0, 1, 0, 0, 36, g(S + D + 1), OVF_EN));

      // wrap: 100 writes, read pointer driven 5 behind; 3-cycle visibility makes fill 8
      reset_all();
      for (int j = 0; j < 100; j++)
         drive(1'b0, 1'b1, (j >= 5) ? (j - 5) % 90 : 0, 1'b1,
               mk(0, 1, j % 45, 0, 0, (j < 8) ? j : 8, g(S + (j % 90)), 0));

      // reset mid-stream at fill 20
      reset_all();
      for (int i = 0; i < 20; i++)
         drive(1'b0, 1'b1, 0, 1'b1, mk(0, 1, i, 0, 0, i, g(S + i), 0));
      drive(1'b1, 1'b0, 0, 1'b1, mk(0, 0, 20, 0, 0, 20, g(S + 20), 0));
      drive(1'b0, 1'b0, 0, 1'b1, mk(0, 0, 0, 0, 0, 0, g(S), 0));

      // power-of-two depth (S=0): plain Gray FIFO behaviour
      reset_all();
      for (int i = 0; i < DB; i++)
         drive(1'b0, 1'b1, 0, 1'b1, mk(1, 1, i, 0, (i >= 12), i, g(i), 0));
      drive(1'b0, 1'b1, 0, 1'b1, mk(1, 0, 0, 1, 1, 16, g(16), 0));
      for (int k = 0; k < 3; k++)
         drive(1'b0, 1'b0, 4, 1'b1, mk(1, 0, 0, 1, 1, 16, g(16), OVF_EN));
      drive(1'b0, 1'b0, 4, 1'b1, mk(1, 0, 0, 0, 1, 12, g(16), OVF_EN));

      // drain and report
      drive(1'b0, 1'b0, 0, 1'b0, '0);
      @(negedge wclk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain obs=%0d actual=%0d required=0", obs_idx, exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
